// File: rtl/img_op_sched.sv
// ---------------------------------------------------------------------------
// img_op_sched
// Sequences one frame job through an external pixel datapath: streams pixels
// out of a source RAM, presents them to the datapath, and writes the results
// to a destination RAM.
//
// Ports
//   clk, rst_n             clock; synchronous active-low reset
//   start, abort           begin a job (IDLE only) / cancel a running job
//   op_sel, op_value,      job configuration, captured when a start is
//   op_thresh, frame_len   accepted
//   busy, done             high in RUN/DRAIN; one-cycle completion pulse
//   rd_en, rd_addr,        source RAM read port (1-cycle read latency)
//   rd_data
//   dp_select, dp_value,   pixel datapath (1-cycle registered latency)
//   dp_threshold,
//   dp_inbyte, dp_outbyte
//   wr_en, wr_addr,        destination RAM write port
//   wr_data
//   sat_count              number of written pixels equal to 8'hFF
//
// Build option
//   IMG_SATCNT_EN          when defined, sat_count is a live saturating
//                          counter; otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module img_op_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  op_sel,
    input  logic [7:0]  op_value,
    input  logic [7:0]  op_thresh,
    input  logic [15:0] frame_len,
    output logic        busy,
    output logic        done,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic [1:0]  dp_select,
    output logic [7:0]  dp_value,
    output logic [7:0]  dp_threshold,
    output logic [7:0]  dp_inbyte,
    input  logic [7:0]  dp_outbyte,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [15:0] sat_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        drain_q, drain_d;
    logic [1:0]  sel_q, sel_d;
    logic [7:0]  value_q, value_d;
    logic [7:0]  thresh_q, thresh_d;
    logic [15:0] len_q, len_d;

    // Two-stage delay line matching RAM read latency plus datapath latency.
    logic        v1_q, v1_d, v2_q, v2_d;
    logic [15:0] a1_q, a1_d, a2_q, a2_d;

    logic        accept;
    logic        abort_hit;

    // Next-state logic: job sequencing and configuration capture.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        drain_d   = drain_q;
        sel_d     = sel_q;
        value_d   = value_q;
        thresh_d  = thresh_q;
        len_d     = len_q;
        accept    = 1'b0;
        abort_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    sel_d    = op_sel;
                    value_d  = op_value;
                    thresh_d = op_thresh;
                    len_d    = frame_len;
                    addr_d   = 16'd0;
                    state_d  = (frame_len != 16'd0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    abort_hit = 1'b1;
                    addr_d    = 16'd0;
                    state_d   = IDLE;
                end else if (addr_q == len_q - 16'd1) begin
                    addr_d  = 16'd0;
                    drain_d = 1'b0;
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + 16'd1;
                end
            end
            DRAIN: begin
                if (abort) begin
                    abort_hit = 1'b1;
                    state_d   = IDLE;
                end else if (drain_q) begin
                    state_d = DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Delay line: an abort flushes both stages so no write escapes afterwards.
    always_comb begin
        v1_d = 1'b0;
        a1_d = 16'd0;
        v2_d = 1'b0;
        a2_d = 16'd0;
        if (!abort_hit) begin
            v1_d = rd_en;
            a1_d = rd_addr;
            v2_d = v1_q;
            a2_d = a1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= 16'd0;
            drain_q  <= 1'b0;
            sel_q    <= 2'd0;
            value_q  <= 8'd0;
            thresh_q <= 8'd0;
            len_q    <= 16'd0;
            v1_q     <= 1'b0;
            a1_q     <= 16'd0;
            v2_q     <= 1'b0;
            a2_q     <= 16'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            drain_q  <= drain_d;
            sel_q    <= sel_d;
            value_q  <= value_d;
            thresh_q <= thresh_d;
            len_q    <= len_d;
            v1_q     <= v1_d;
            a1_q     <= a1_d;
            v2_q     <= v2_d;
            a2_q     <= a2_d;
        end
    end

    assign busy         = (state_q == RUN) || (state_q == DRAIN);
    assign done         = (state_q == DONE);
    assign rd_en        = (state_q == RUN);
    assign rd_addr      = rd_en ? addr_q : 16'd0;
    assign dp_select    = sel_q;
    assign dp_value     = value_q;
    assign dp_threshold = thresh_q;
    assign dp_inbyte    = rd_data;
    assign wr_en        = v2_q;
    assign wr_addr      = v2_q ? a2_q : 16'd0;
    assign wr_data      = v2_q ? dp_outbyte : 8'd0;

`ifdef IMG_SATCNT_EN
    logic [15:0] sat_q, sat_d;

    // Saturated-pixel counter: restarts with each accepted job and sticks
    // at its maximum rather than wrapping.
    always_comb begin
        sat_d = sat_q;
        if (accept) begin
            sat_d = 16'd0;
        end else if (wr_en && (wr_data == 8'hFF) && (sat_q != 16'hFFFF)) begin
            sat_d = sat_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_q <= 16'd0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_count = sat_q;
`else
    assign sat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_img_op_sched.sv
// ---------------------------------------------------------------------------
// tb_img_op_sched
// Self-checking bench for img_op_sched. Models the source RAM and the pixel
// datapath, issues directed jobs, and scores the destination writes through
// a queue of hand-computed expected writes.
// ---------------------------------------------------------------------------
module tb_img_op_sched;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [1:0]  op_sel;
    logic [7:0]  op_value;
    logic [7:0]  op_thresh;
    logic [15:0] frame_len;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic [1:0]  dp_select;
    logic [7:0]  dp_value;
    logic [7:0]  dp_threshold;
    logic [7:0]  dp_inbyte;
    logic [7:0]  dp_outbyte;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] sat_count;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wrExp_t;

    wrExp_t      sb[$];
    wrExp_t      popped;
    logic [7:0]  mem [0:15];
    int          cyc;
    int          vectors;
    int          miscompares;

    img_op_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .op_sel       (op_sel),
        .op_value     (op_value),
        .op_thresh    (op_thresh),
        .frame_len    (frame_len),
        .busy         (busy),
        .done         (done),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .dp_select    (dp_select),
        .dp_value     (dp_value),
        .dp_threshold (dp_threshold),
        .dp_inbyte    (dp_inbyte),
        .dp_outbyte   (dp_outbyte),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .sat_count    (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle k after a start edge S is observed with cyc == S + k - 1.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Source RAM with one cycle of read latency.
    always @(posedge clk) rd_data <= mem[rd_addr[3:0]];

    // Pixel datapath reference: saturating brighten/darken, threshold, invert.
    function automatic logic [7:0] pixelOp(input logic [1:0] sel, input logic [7:0] val,
                                           input logic [7:0] thr, input logic [7:0] pix);
        logic [8:0] sum;
        sum = {1'b0, pix} + {1'b0, val};
        case (sel)
            2'd0:    pixelOp = sum[8] ? 8'hFF : sum[7:0];
            2'd1:    pixelOp = (pix < val) ? 8'h00 : pix - val;
            2'd2:    pixelOp = (pix >= thr) ? 8'hFF : 8'h00;
            default: pixelOp = ~pix;
        endcase
    endfunction

    always @(posedge clk) dp_outbyte <= pixelOp(dp_select, dp_value, dp_threshold, dp_inbyte);

    task automatic checkOutput(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cyc %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic expectWrite(input int addr, input int data, input int when);
        wrExp_t e;
        e.addr = addr;
        e.data = data;
        e.cyc  = when;
        sb.push_back(e);
    endtask

    // Presents a job configuration with start for one edge; returns the
    // cycle stamp of cycle 1 of the job.
    task automatic applyStimulus(input logic [1:0] sel, input logic [7:0] val,
                                 input logic [7:0] thr, input logic [15:0] len,
                                 output int s);
        @(negedge clk);
        op_sel    = sel;
        op_value  = val;
        op_thresh = thr;
        frame_len = len;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        s = cyc;
    endtask

    // Waits for the done pulse, tallying reads and busy cycles on the way.
    task automatic waitDone(input string tag, input int expDoneCyc,
                            input int expReads, input int expBusy);
        int reads = 0;
        int busyCycles = 0;
        int doneCyc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rd_en) reads++;
            if (busy) busyCycles++;
            if (done) begin
                doneCyc = cyc;
                checkOutput({tag, "BusyAtDone"}, busy, 0);
                break;
            end
        end
        checkOutput({tag, "DoneCycle"}, doneCyc, expDoneCyc);
        checkOutput({tag, "Reads"}, reads, expReads);
        checkOutput({tag, "BusyCycles"}, busyCycles, expBusy);
        @(negedge clk);
        checkOutput({tag, "DoneOneCycle"}, done, 0);
    endtask

    // Scoreboard monitor: every destination write must match the oldest
    // expectation; idle address buses must sit at zero.
    always @(negedge clk) begin
        if (wr_en) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpectedWrite: got addr %0d data 0x%0h, expected no write at cyc %0d",
                         wr_addr, wr_data, cyc);
            end else begin
                popped = sb.pop_front();
                checkOutput("wrAddr", wr_addr, popped.addr);
                checkOutput("wrData", wr_data, popped.data);
                checkOutput("wrCycle", cyc, popped.cyc);
            end
        end else begin
            checkOutput("wrAddrIdle", wr_addr, 0);
        end
        if (!rd_en) checkOutput("rdAddrIdle", rd_addr, 0);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s;
        int satExp;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        op_sel      = 2'd0;
        op_value    = 8'd0;
        op_thresh   = 8'd0;
        frame_len   = 16'd0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstRdEn", rd_en, 0);
        checkOutput("rstWrEn", wr_en, 0);
        checkOutput("rstDpSelect", dp_select, 0);
        checkOutput("rstSat", sat_count, 0);
        rst_n = 1'b1;

        // Invert four pixels; writes at cycles 3..6, done at cycle 7.
        mem[0] = 8'h00; mem[1] = 8'h10; mem[2] = 8'hF0; mem[3] = 8'hFF;
        applyStimulus(2'd3, 8'h00, 8'h00, 16'd4, s);
        checkOutput("invDpSelect", dp_select, 3);
        expectWrite(0, 8'hFF, s + 2);
        expectWrite(1, 8'hEF, s + 3);
        expectWrite(2, 8'h0F, s + 4);
        expectWrite(3, 8'h00, s + 5);
        waitDone("inv", s + 6, 4, 6);
`ifdef IMG_SATCNT_EN
        satExp = 1;
`else
        satExp = 0;
`endif
        checkOutput("invSat", sat_count, satExp);

        // Brighten by 0x20 with saturation at the top.
        mem[0] = 8'hE0; mem[1] = 8'hE1; mem[2] = 8'h10;
        applyStimulus(2'd0, 8'h20, 8'h00, 16'd3, s);
        checkOutput("brtDpValue", dp_value, 8'h20);
        expectWrite(0, 8'hFF, s + 2);
        expectWrite(1, 8'hFF, s + 3);
        expectWrite(2, 8'h30, s + 4);
        waitDone("brt", s + 5, 3, 5);
`ifdef IMG_SATCNT_EN
        satExp = 2;
`else
        satExp = 0;
`endif
        checkOutput("brtSat", sat_count, satExp);

        // Empty frame: done in cycle 1, never busy, no traffic.
        applyStimulus(2'd1, 8'h05, 8'h00, 16'd0, s);
        waitDone("empty", s, 0, 0);

        // Darken job of eight pixels aborted during cycle 4.
        mem[0] = 8'h35; mem[1] = 8'h05;
        applyStimulus(2'd1, 8'h10, 8'h00, 16'd8, s);
        expectWrite(0, 8'h25, s + 2);
        expectWrite(1, 8'h00, s + 3);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("abtBusyBefore", busy, 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abtRdEn", rd_en, 0);
        checkOutput("abtWrEn", wr_en, 0);
        checkOutput("abtBusy", busy, 0);
        checkOutput("abtDone", done, 0);

        // A new job is accepted straight after the abort.
        applyStimulus(2'd3, 8'h00, 8'h00, 16'd2, s);
        checkOutput("postAbtBusy", busy, 1);
        expectWrite(0, 8'hCA, s + 2);
        expectWrite(1, 8'hFA, s + 3);
        waitDone("postAbt", s + 4, 2, 4);

        // Threshold job with a competing start pulsed in cycle 2.
        mem[0] = 8'h7F; mem[1] = 8'h80; mem[2] = 8'h81; mem[3] = 8'h00;
        applyStimulus(2'd2, 8'h00, 8'h80, 16'd4, s);
        expectWrite(0, 8'h00, s + 2);
        expectWrite(1, 8'hFF, s + 3);
        expectWrite(2, 8'hFF, s + 4);
        expectWrite(3, 8'h00, s + 5);
        fork
            begin
                @(posedge clk);
                #1;
                op_sel    = 2'd3;
                op_thresh = 8'h11;
                frame_len = 16'd1;
                start     = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                checkOutput("ignDpSelect", dp_select, 2);
                checkOutput("ignDpThresh", dp_threshold, 8'h80);
            end
            waitDone("ign", s + 6, 4, 6);
        join

        // Reset asserted during the first DRAIN cycle (cycle 4 of a 3-pixel job).
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
        applyStimulus(2'd3, 8'h00, 8'h00, 16'd3, s);
        expectWrite(0, 8'hFE, s + 2);
        expectWrite(1, 8'hFD, s + 3);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("drstBusy", busy, 0);
        checkOutput("drstDone", done, 0);
        checkOutput("drstRdEn", rd_en, 0);
        checkOutput("drstWrEn", wr_en, 0);
        checkOutput("drstDpSelect", dp_select, 0);
        checkOutput("drstSat", sat_count, 0);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("drstNoDone", done, 0);
        end

        checkOutput("sbEmpty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/img_op_sched.md
IMG_OP_SCHED -- requirements
Module: img_op_sched

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  synchronous, active-low reset.
REQ-003 SHALL have ports: start  in  1  begin frame job; sampled in IDLE only.
REQ-004 SHALL have ports: abort  in  1  cancel job in progress.
REQ-005 SHALL have ports: op_sel  in  2  operation: 00 brighten, 01 darken, 10 threshold, 11 invert.
REQ-006 SHALL have ports: op_value  in  8  brighten/darken amount; op_thresh  in  8  threshold level.
REQ-007 SHALL have ports: frame_len  in  16  pixel count of job (0..65535).
REQ-008 SHALL have ports: busy  out  1  high in RUN and DRAIN; done  out  1  one-cycle completion pulse.
REQ-009 SHALL have ports: rd_en  out  1; rd_addr  out  16; rd_data  in  8 (source RAM, 1-cycle read latency).
REQ-010 SHALL have ports: dp_select  out  2; dp_value  out  8; dp_threshold  out  8; dp_inbyte  out  8; dp_outbyte  in  8 (pixel datapath, 1-cycle registered latency).
REQ-011 SHALL have ports: wr_en  out  1; wr_addr  out  16; wr_data  out  8 (destination RAM).
REQ-012 SHALL have ports: sat_count  out  16  count of written pixels equal to 8'hFF.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE: start=1 latches op_sel, op_value, op_thresh, frame_len; next state RUN (frame_len>0) or DONE (frame_len=0).
REQ-015 dp_select/dp_value/dp_threshold SHALL be driven from latched registers and held constant until next accepted start.
REQ-016 RUN: rd_en=1 each cycle, rd_addr=0,1,...,frame_len-1 on consecutive cycles; after last address, next state DRAIN.
REQ-017 dp_inbyte SHALL equal rd_data combinationally.
REQ-018 A read issued at cycle k SHALL produce wr_en=1, wr_addr=k's address, wr_data=dp_outbyte at cycle k+2 (2-stage valid/address delay line).
REQ-019 DRAIN: exactly 2 cycles, no reads, flushes in-flight writes; then DONE.
REQ-020 DONE: done=1, busy=0 for one cycle; then IDLE.
REQ-021 Job of N>0 pixels: first rd_en in cycle 1 after start edge, last wr_en in cycle N+2, done in cycle N+3.
REQ-022 start while busy or in DONE SHALL be ignored; latched config unchanged.
REQ-023 abort=1 in RUN or DRAIN: next cycle rd_en=0, wr_en=0, delay line cleared, state IDLE, no done pulse; abort in IDLE/DONE has no effect.
REQ-024 Simultaneous start and abort in IDLE: start wins.
REQ-025 rd_addr/wr_addr SHALL be 0 whenever the respective enable is 0.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, rd_en=0, wr_en=0, addresses 0, delay line cleared, latched config 0, sat_count 0.
REQ-027 Reset mid-job SHALL discard the job without done pulse; reset dominates start and abort.

Configuration
REQ-028 Macro IMG_SATCNT_EN defined: sat_count clears on accepted start, increments by 1 each cycle wr_en=1 and wr_data=8'hFF, saturates at 16'hFFFF, holds after done/abort.
REQ-029 IMG_SATCNT_EN undefined: sat_count tied to 16'h0000; no counter logic.

Verification
REQ-030 Reset then start, op_sel=11, frame_len=4, RAM {00,10,F0,FF} -> writes {FF,EF,0F,00} at addr 0..3, cycles 3..6; done at cycle 7.
REQ-031 op_sel=00, op_value=20, pixels {E0,E1,10} -> writes {FF,FF,30}; with IMG_SATCNT_EN sat_count=2, without it 0.
REQ-032 frame_len=0, start -> no rd_en/wr_en, done pulse in cycle 1, busy never high.
REQ-033 frame_len=8, abort at cycle 4 -> no rd_en or wr_en from cycle 5, no done, IDLE; new start accepted next cycle.
REQ-034 start pulsed during RUN with different op_sel -> ignored; dp_select unchanged, job completes with original op.
REQ-035 rst_n=0 during DRAIN -> all outputs at reset values next cycle, no done pulse, no further wr_en.
